fsm_control_param: RTL and testbench

//  Parametrised successor of the FSM control block.

---
 rtl/fsm_control_param.sv | 189 ++++++++++++++++++
 tb/tb_fsm_control_param.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fsm_control_param.sv
// -----------------------------------------------------------------------------
// fsm_control_param
//
// Link control sequencer. Walks the link through RESET/INIT/IDLE/ACTIVE/ERROR,
// latches the per-FIFO almost-full/almost-empty thresholds while in INIT, and
// reports idle/active/error status to the datapath from the FIFO flags.
//
// Parameters
//   NUM_FIFOS   : number of monitored FIFOs (>= 1)
//   UMB_W       : width of a single threshold field
//   IDLE_CYCLES : consecutive all-empty cycles in ACTIVE before dropping to IDLE
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-low reset
//   init           in   request (re)initialisation / threshold load
//   umbrales_in    in   threshold fields, field i = [i*UMB_W +: UMB_W]
//   fifo_empty     in   per-FIFO empty flags
//   fifo_error     in   per-FIFO overflow/underflow error flags
//   err_clear      in   clears sticky errors and leaves ERROR
//   umbrales_out   out  registered threshold copy for the FIFOs
//   umbrales_valid out  umbrales_out holds a committed set
//   state_o        out  RESET=0 INIT=1 IDLE=2 ACTIVE=3 ERROR=4
//   idle           out  state_o == IDLE
//   active         out  state_o == ACTIVE
//   error          out  sticky OR of fifo_error since the last clear
//   error_any      out  |error
// -----------------------------------------------------------------------------
module fsm_control_param #(
    parameter int NUM_FIFOS   = 5,
    parameter int UMB_W       = 4,
    parameter int IDLE_CYCLES = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         init,
    input  logic [NUM_FIFOS*UMB_W-1:0]   umbrales_in,
    input  logic [NUM_FIFOS-1:0]         fifo_empty,
    input  logic [NUM_FIFOS-1:0]         fifo_error,
    input  logic                         err_clear,
    output logic [NUM_FIFOS*UMB_W-1:0]   umbrales_out,
    output logic                         umbrales_valid,
    output logic [2:0]                   state_o,
    output logic                         idle,
    output logic                         active,
    output logic [NUM_FIFOS-1:0]         error,
    output logic                         error_any
);

    localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
    // Count value on which the last all-empty cycle of the debounce window lands.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    state_e                       state_q, state_d;
    logic [NUM_FIFOS*UMB_W-1:0]   umb_q, umb_d;
    logic                         valid_q, valid_d;
    logic [NUM_FIFOS-1:0]         err_q, err_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;

    logic                         err_hit_s;
    logic                         all_empty_s;

    assign err_hit_s   = |fifo_error;
    assign all_empty_s = &fifo_empty;

    // Next-state and next-register computation; error detection outranks every
    // other request in the operating states, including init.
    always_comb begin
        state_d = state_q;
        umb_d   = umb_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_INIT;
                cnt_d   = {CNT_W{1'b0}};
            end
            ST_INIT: begin
                if (err_hit_s) begin
                    state_d = ST_ERROR;
                    err_d   = err_q | fifo_error;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    // Thresholds track the input every INIT cycle; the value
                    // present on the exit edge is the committed one.
                    umb_d = umbrales_in;
                    if (!init) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
            ST_IDLE: begin
                if (err_hit_s) begin
                    state_d = ST_ERROR;
                    err_d   = err_q | fifo_error;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (init) begin
                    state_d = ST_INIT;
                    valid_d = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (!all_empty_s) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            ST_ACTIVE: begin
                if (err_hit_s) begin
                    state_d = ST_ERROR;
                    err_d   = err_q | fifo_error;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (init) begin
                    state_d = ST_INIT;
                    valid_d = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (all_empty_s) begin
                    // Debounce: only a full window of consecutive empty
                    // cycles drops the link back to IDLE.
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            ST_ERROR: begin
                // init is deliberately ignored here; only err_clear leaves.
                if (err_clear && !err_hit_s) begin
                    state_d = ST_INIT;
                    err_d   = {NUM_FIFOS{1'b0}};
                    valid_d = 1'b0;
                end else begin
                    state_d = ST_ERROR;
                    err_d   = err_q | fifo_error;
                end
                cnt_d = {CNT_W{1'b0}};
            end
            default: begin
                // Corrupted state encoding: restart the sequence.
                state_d = ST_RESET;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RESET;
            umb_q   <= {(NUM_FIFOS*UMB_W){1'b0}};
            valid_q <= 1'b0;
            err_q   <= {NUM_FIFOS{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            umb_q   <= umb_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign umbrales_out   = umb_q;
    assign umbrales_valid = valid_q;
    assign state_o        = state_q;
    assign error          = err_q;
    // Status decodes depend only on registered state, so they cannot glitch
    // on input activity.
    assign idle           = (state_q == ST_IDLE);
    assign active         = (state_q == ST_ACTIVE);
    assign error_any      = |err_q;

endmodule

// File: tb/tb_fsm_control_param.sv
// -----------------------------------------------------------------------------
// Testbench for fsm_control_param (NUM_FIFOS=5, UMB_W=4, IDLE_CYCLES=3).
// Stimulus pushes hand-computed expected outputs into a scoreboard queue; an
// independent monitor pops one entry after each rising edge (or after an
// asynchronous reset assertion) and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_fsm_control_param;

    localparam logic [2:0] S_RST = 3'd0;
    localparam logic [2:0] S_INI = 3'd1;
    localparam logic [2:0] S_IDL = 3'd2;
    localparam logic [2:0] S_ACT = 3'd3;
    localparam logic [2:0] S_ERR = 3'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        init = 1'b0;
    logic [19:0] umbrales_in = 20'h0;
    logic [4:0]  fifo_empty = 5'h1F;
    logic [4:0]  fifo_error = 5'h0;
    logic        err_clear = 1'b0;
    logic [19:0] umbrales_out;
    logic        umbrales_valid;
    logic [2:0]  state_o;
    logic        idle;
    logic        active;
    logic [4:0]  error;
    logic        error_any;

    fsm_control_param #(
        .NUM_FIFOS  (5),
        .UMB_W      (4),
        .IDLE_CYCLES(3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .umbrales_in   (umbrales_in),
        .fifo_empty    (fifo_empty),
        .fifo_error    (fifo_error),
        .err_clear     (err_clear),
        .umbrales_out  (umbrales_out),
        .umbrales_valid(umbrales_valid),
        .state_o       (state_o),
        .idle          (idle),
        .active        (active),
        .error         (error),
        .error_any     (error_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] vec;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Build the expected output vector; status flags are decoded from the
    // expected state/error exactly as the outputs are defined.
    task automatic expect_now(input string nm, input logic [2:0] st, input logic [19:0] umb,
                              input logic v, input logic [4:0] er);
        exp_t e;
        e.nm  = nm;
        e.vec = {st, umb, v, er, (st == S_IDL), (st == S_ACT), (er != 5'h0)};
        sb_q.push_back(e);
    endtask

    // Expectation for the state after the next rising edge; returns at the
    // following falling edge, where the next inputs are driven.
    task automatic step(input string nm, input logic [2:0] st, input logic [19:0] umb,
                        input logic v, input logic [4:0] er);
        expect_now(nm, st, umb, v, er);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: compare one scoreboard entry after each edge or async reset.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(posedge clk or negedge reset);
            #1;
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {state_o, umbrales_out, umbrales_valid, error, idle, active, error_any};
                n_total++;
                if (act === e.vec) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got %h expected %h (state,umb,valid,err,idle,active,any)",
                             e.nm, act, e.vec);
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        // Held in reset
        step("reset_hold", S_RST, 20'h0, 1'b0, 5'h00);

        // Release: INIT after one edge, thresholds not yet loaded
        reset = 1'b1; init = 1'b1; umbrales_in = 20'h12345;
        step("rel_init", S_INI, 20'h0, 1'b0, 5'h00);
        step("load_1", S_INI, 20'h12345, 1'b0, 5'h00);
        umbrales_in = 20'h0ABCD;
        step("load_2", S_INI, 20'h0ABCD, 1'b0, 5'h00);
        init = 1'b0;
        step("commit", S_IDL, 20'h0ABCD, 1'b1, 5'h00);

        // Activity and debounce window
        fifo_empty = 5'b11011;
        step("go_active", S_ACT, 20'h0ABCD, 1'b1, 5'h00);
        fifo_empty = 5'h1F;
        step("db_e1", S_ACT, 20'h0ABCD, 1'b1, 5'h00);
        step("db_e2", S_ACT, 20'h0ABCD, 1'b1, 5'h00);
        fifo_empty = 5'b01111;
        step("db_break", S_ACT, 20'h0ABCD, 1'b1, 5'h00);
        fifo_empty = 5'h1F;
        step("db_r1", S_ACT, 20'h0ABCD, 1'b1, 5'h00);
        step("db_r2", S_ACT, 20'h0ABCD, 1'b1, 5'h00);
        step("db_r3_idle", S_IDL, 20'h0ABCD, 1'b1, 5'h00);

        // init beats activity in IDLE
        init = 1'b1; fifo_empty = 5'h00;
        step("init_pri", S_INI, 20'h0ABCD, 1'b0, 5'h00);
        init = 1'b0; fifo_empty = 5'h1F; umbrales_in = 20'h0ABCD;
        step("back_idle", S_IDL, 20'h0ABCD, 1'b1, 5'h00);
        fifo_empty = 5'b11110;
        step("active2", S_ACT, 20'h0ABCD, 1'b1, 5'h00);

        // Error beats init in ACTIVE
        fifo_error = 5'b10100; init = 1'b1;
        step("err_cap", S_ERR, 20'h0ABCD, 1'b1, 5'b10100);
        fifo_error = 5'h00; init = 1'b0;
        step("err_sticky", S_ERR, 20'h0ABCD, 1'b1, 5'b10100);
        init = 1'b1;
        step("init_ignored", S_ERR, 20'h0ABCD, 1'b1, 5'b10100);
        init = 1'b0; fifo_error = 5'b00001;
        step("err_accum", S_ERR, 20'h0ABCD, 1'b1, 5'b10101);

        // Clear blocked while an error is still asserted
        err_clear = 1'b1;
        step("clr_blocked", S_ERR, 20'h0ABCD, 1'b1, 5'b10101);
        fifo_error = 5'h00;
        step("clr_ok", S_INI, 20'h0ABCD, 1'b0, 5'h00);
        err_clear = 1'b0;
        step("reinit_idle", S_IDL, 20'h0ABCD, 1'b1, 5'h00);

        // Error in INIT takes priority over the threshold load
        init = 1'b1;
        step("init3", S_INI, 20'h0ABCD, 1'b0, 5'h00);
        fifo_error = 5'b01000; umbrales_in = 20'h55555;
        step("err_in_init", S_ERR, 20'h0ABCD, 1'b0, 5'b01000);
        fifo_error = 5'h00; init = 1'b0; err_clear = 1'b1; umbrales_in = 20'h0ABCD;
        step("clr2", S_INI, 20'h0ABCD, 1'b0, 5'h00);
        err_clear = 1'b0;
        step("idle3", S_IDL, 20'h0ABCD, 1'b1, 5'h00);
        fifo_empty = 5'h00;
        step("active3", S_ACT, 20'h0ABCD, 1'b1, 5'h00);

        // Asynchronous reset mid-ACTIVE, checked before the next edge
        expect_now("async_reset", S_RST, 20'h0, 1'b0, 5'h00);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1; fifo_empty = 5'h1F; init = 1'b1;
        step("rel2_init", S_INI, 20'h0, 1'b0, 5'h00);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending expected 0 pending", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
